// File: rtl/collision_detector.sv
// -----------------------------------------------------------------------------
// collision_detector
//
// Accumulates ship/asteroid and torpedo/asteroid pixel overlaps over one video
// frame. At each frame boundary it issues single-cycle hit pulses for the lives
// counter and the score accumulator. It also runs the ship's post-hit grace
// period, including the blink mask used while that period is active.
//
// Ports
//   clk          : pixel clock
//   resetN       : synchronous, active-low reset
//   frame_pulse  : single-cycle frame boundary marker (vsync rising edge)
//   game_over    : level; while high, all hit reporting is suppressed
//   draw_ship    : ship pixel enable
//   draw_rock    : OR of all asteroid pixel enables
//   draw_torp    : per-torpedo pixel enables [T_NUM]
//   ship_hit     : one-cycle pulse, at most one per frame
//   torp_hit     : one-cycle per-torpedo hit pulses [T_NUM]
//   score_add    : one-cycle pulse when any torp_hit bit is set
//   score_cnt    : popcount of torp_hit, 0 when score_add is low
//   ship_mask    : ship draw mask (low on blink-off frames during grace)
//   grace        : high while in the grace period
// -----------------------------------------------------------------------------
module collision_detector #(
    parameter int T_NUM        = 4,
    parameter int MIN_OVERLAP  = 2,
    parameter int GRACE_FRAMES = 90
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_pulse,
    input  logic                         game_over,
    input  logic                         draw_ship,
    input  logic                         draw_rock,
    input  logic [T_NUM-1:0]             draw_torp,
    output logic                         ship_hit,
    output logic [T_NUM-1:0]             torp_hit,
    output logic                         score_add,
    output logic [$clog2(T_NUM+1)-1:0]   score_cnt,
    output logic                         ship_mask,
    output logic                         grace
);

    localparam int OV_W = $clog2(MIN_OVERLAP + 1);
    localparam int G_W  = $clog2(GRACE_FRAMES + 1);
    localparam int S_W  = $clog2(T_NUM + 1);
    // Blink toggles every 8 frames; fall back to the top bit for tiny counters.
    localparam int BLINK_BIT = (G_W > 3) ? 3 : G_W - 1;

    localparam logic [OV_W-1:0] OV_SAT    = OV_W'(MIN_OVERLAP);
    localparam logic [G_W-1:0]  GCNT_LOAD = G_W'(GRACE_FRAMES);
    localparam logic [G_W-1:0]  GCNT_ONE  = G_W'(1);

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        GRACE    = 2'd1,
        DISABLED = 2'd2
    } state_t;

    state_t             r_state;
    logic [G_W-1:0]     r_gcnt;
    logic [OV_W-1:0]    r_ov_cnt;
    logic [T_NUM-1:0]   r_torp_seen;
    logic               r_ship_hit;
    logic [T_NUM-1:0]   r_torp_hit;
    logic               r_score_add;
    logic [S_W-1:0]     r_score_cnt;
    logic               r_ship_mask;
    logic               r_grace;

    logic               w_ov_pix;
    logic               w_ov_sat;
    logic [T_NUM-1:0]   w_torp_pix;
    logic [S_W-1:0]     w_popcnt;
    logic [G_W-1:0]     w_gcnt_dec;

    assign w_ov_pix   = draw_ship & draw_rock;
    assign w_ov_sat   = (r_ov_cnt == OV_SAT);
    assign w_gcnt_dec = r_gcnt - GCNT_ONE;

    genvar gi;
    generate
        for (gi = 0; gi < T_NUM; gi++) begin : g_torp_pix
            assign w_torp_pix[gi] = draw_torp[gi] & draw_rock;
        end
    endgenerate

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < T_NUM; i++) begin
            w_popcnt = w_popcnt + S_W'(r_torp_seen[i]);
        end
    end

    // Per-frame accumulators. On the boundary cycle they restart from that
    // cycle's pixel, so it belongs to the new frame and is never lost.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_ov_cnt    <= '0;
            r_torp_seen <= '0;
        end else if (frame_pulse) begin
            r_ov_cnt    <= w_ov_pix ? OV_W'(1) : '0;
            r_torp_seen <= w_torp_pix;
        end else begin
            if (w_ov_pix && !w_ov_sat) begin
                r_ov_cnt <= r_ov_cnt + OV_W'(1);
            end
            r_torp_seen <= r_torp_seen | w_torp_pix;
        end
    end

    // Frame-rate state machine with registered outputs. game_over has
    // priority over everything except reset, so a frame ending on the same
    // cycle game_over rises produces no pulses.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= ARMED;
            r_gcnt      <= '0;
            r_ship_hit  <= 1'b0;
            r_torp_hit  <= '0;
            r_score_add <= 1'b0;
            r_score_cnt <= '0;
            r_grace     <= 1'b0;
            r_ship_mask <= 1'b1;
        end else begin
            r_ship_hit  <= 1'b0;
            r_torp_hit  <= '0;
            r_score_add <= 1'b0;
            r_score_cnt <= '0;
            if (game_over) begin
                r_state     <= DISABLED;
                r_grace     <= 1'b0;
                r_ship_mask <= 1'b1;
            end else begin
                case (r_state)
                    DISABLED: begin
                        // Respawn: start spawn protection immediately.
                        r_state     <= GRACE;
                        r_gcnt      <= GCNT_LOAD;
                        r_grace     <= 1'b1;
                        r_ship_mask <= GCNT_LOAD[BLINK_BIT];
                    end
                    ARMED: begin
                        if (frame_pulse) begin
                            r_torp_hit  <= r_torp_seen;
                            r_score_add <= |r_torp_seen;
                            r_score_cnt <= w_popcnt;
                            if (w_ov_sat) begin
                                r_ship_hit  <= 1'b1;
                                r_state     <= GRACE;
                                r_gcnt      <= GCNT_LOAD;
                                r_grace     <= 1'b1;
                                r_ship_mask <= GCNT_LOAD[BLINK_BIT];
                            end
                        end
                    end
                    GRACE: begin
                        if (frame_pulse) begin
                            r_torp_hit  <= r_torp_seen;
                            r_score_add <= |r_torp_seen;
                            r_score_cnt <= w_popcnt;
                            r_gcnt      <= w_gcnt_dec;
                            if (r_gcnt == GCNT_ONE) begin
                                r_state     <= ARMED;
                                r_grace     <= 1'b0;
                                r_ship_mask <= 1'b1;
                            end else begin
                                r_ship_mask <= w_gcnt_dec[BLINK_BIT];
                            end
                        end
                    end
                    default: begin
                        r_state     <= ARMED;
                        r_grace     <= 1'b0;
                        r_ship_mask <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ship_hit  = r_ship_hit;
    assign torp_hit  = r_torp_hit;
    assign score_add = r_score_add;
    assign score_cnt = r_score_cnt;
    assign ship_mask = r_ship_mask;
    assign grace     = r_grace;

endmodule

// File: tb/tb_collision_detector.sv
// -----------------------------------------------------------------------------
// tb_collision_detector
//
// Directed, self-checking bench for collision_detector with default
// parameters (T_NUM=4, MIN_OVERLAP=2, GRACE_FRAMES=90). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_collision_detector;

    logic       clk;
    logic       resetN;
    logic       frame_pulse;
    logic       game_over;
    logic       draw_ship;
    logic       draw_rock;
    logic [3:0] draw_torp;
    logic       ship_hit;
    logic [3:0] torp_hit;
    logic       score_add;
    logic [2:0] score_cnt;
    logic       ship_mask;
    logic       grace;

    int n_checks = 0;
    int n_fail   = 0;

    collision_detector #(
        .T_NUM        (4),
        .MIN_OVERLAP  (2),
        .GRACE_FRAMES (90)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .frame_pulse (frame_pulse),
        .game_over   (game_over),
        .draw_ship   (draw_ship),
        .draw_rock   (draw_rock),
        .draw_torp   (draw_torp),
        .ship_hit    (ship_hit),
        .torp_hit    (torp_hit),
        .score_add   (score_add),
        .score_cnt   (score_cnt),
        .ship_mask   (ship_mask),
        .grace       (grace)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given pixel/control inputs.
    task automatic step(input logic s, input logic r, input logic [3:0] t,
                        input logic fp, input logic go);
        draw_ship   = s;
        draw_rock   = r;
        draw_torp   = t;
        frame_pulse = fp;
        game_over   = go;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic overlap();
        step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic fpulse();
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        idle();
        idle();
        resetN = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".ship_hit"},  32'(ship_hit),  32'd0);
        check({tag, ".torp_hit"},  32'(torp_hit),  32'd0);
        check({tag, ".score_add"}, 32'(score_add), 32'd0);
        check({tag, ".score_cnt"}, 32'(score_cnt), 32'd0);
    endtask

    initial begin
        resetN      = 1'b0;
        frame_pulse = 1'b0;
        game_over   = 1'b0;
        draw_ship   = 1'b0;
        draw_rock   = 1'b0;
        draw_torp   = 4'b0000;
        @(posedge clk);
        #1;

        // ---- reset state ----
        do_reset();
        $display("section: reset state");
        check_quiet("rst");
        check("rst.grace", 32'(grace),     32'd0);
        check("rst.mask",  32'(ship_mask), 32'd1);

        // ---- 3 overlaps then frame pulse -> ship hit ----
        $display("section: ship hit");
        overlap(); overlap(); overlap(); idle();
        fpulse();
        check("t1.ship_hit", 32'(ship_hit),  32'd1);
        check("t1.grace",    32'(grace),     32'd1);
        check("t1.mask",     32'(ship_mask), 32'd1);  // gcnt=90, bit3=1
        idle();
        check("t1.ship_hit_1cyc", 32'(ship_hit), 32'd0);
        check("t1.grace_hold",    32'(grace),    32'd1);

        // ---- grace period with overlap every frame ----
        $display("section: grace period");
        for (int k = 1; k <= 90; k++) begin
            overlap(); overlap();
            fpulse();
            check($sformatf("t3.ship_hit.f%0d", k), 32'(ship_hit), 32'd0);
            check($sformatf("t3.grace.f%0d", k), 32'(grace), (k < 90) ? 32'd1 : 32'd0);
            check($sformatf("t3.mask.f%0d", k), 32'(ship_mask),
                  (k < 90) ? 32'(((90 - k) >> 3) & 1) : 32'd1);
        end
        overlap(); overlap();
        fpulse();
        check("t3.ship_hit.f91", 32'(ship_hit), 32'd1);
        check("t3.grace.f91",    32'(grace),    32'd1);

        // ---- reset mid-grace ----
        $display("section: reset mid-grace");
        idle(); idle();
        resetN = 1'b0;
        overlap();
        check("t6r.grace",    32'(grace),     32'd0);
        check("t6r.mask",     32'(ship_mask), 32'd1);
        check("t6r.ship_hit", 32'(ship_hit),  32'd0);
        resetN = 1'b1;
        overlap(); overlap();
        fpulse();
        check("t6r.armed_hit", 32'(ship_hit), 32'd1);

        // ---- single overlap per frame never accumulates across frames ----
        $display("section: below threshold");
        do_reset();
        overlap(); idle();
        fpulse();
        check("t2.f1.ship_hit", 32'(ship_hit), 32'd0);
        overlap();
        fpulse();
        check("t2.f2.ship_hit", 32'(ship_hit), 32'd0);
        overlap();
        fpulse();
        check("t2.f3.ship_hit", 32'(ship_hit), 32'd0);
        overlap(); overlap();
        fpulse();
        check("t2.exact_min", 32'(ship_hit), 32'd1);

        // ---- overlap on the boundary cycle counts toward the next frame ----
        $display("section: boundary pixel");
        do_reset();
        step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
        check("t5.boundary_frame", 32'(ship_hit), 32'd0);
        overlap();
        fpulse();
        check("t5.carried", 32'(ship_hit), 32'd1);

        // ---- torpedo hits and score ----
        $display("section: torpedo hits");
        do_reset();
        step(1'b0, 1'b1, 4'b1010, 1'b0, 1'b0);
        idle();
        fpulse();
        check("t4.torp_hit",  32'(torp_hit),  32'hA);
        check("t4.score_add", 32'(score_add), 32'd1);
        check("t4.score_cnt", 32'(score_cnt), 32'd2);
        check("t4.ship_hit",  32'(ship_hit),  32'd0);
        idle();
        check_quiet("t4.after");
        fpulse();
        check_quiet("t4.empty_frame");
        step(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b1000, 1'b0, 1'b0);   // no rock: no hit
        fpulse();
        check("t4.sticky.torp_hit",  32'(torp_hit),  32'h5);
        check("t4.sticky.score_cnt", 32'(score_cnt), 32'd2);
        step(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        fpulse();
        check("t4.all.torp_hit",  32'(torp_hit),  32'hF);
        check("t4.all.score_cnt", 32'(score_cnt), 32'd4);
        step(1'b0, 1'b1, 4'b0010, 1'b1, 1'b0);   // torp on the boundary cycle
        check_quiet("t4.boundary_torp");
        fpulse();                                 // back-to-back pulse
        check("t4.b2b.torp_hit",  32'(torp_hit),  32'h2);
        check("t4.b2b.score_add", 32'(score_add), 32'd1);
        check("t4.b2b.score_cnt", 32'(score_cnt), 32'd1);

        // ---- game over with pending overlaps ----
        $display("section: game over");
        do_reset();
        overlap(); overlap();
        step(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
        check_quiet("t6.go_enter");
        check("t6.go.grace", 32'(grace),     32'd0);
        check("t6.go.mask",  32'(ship_mask), 32'd1);
        step(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
        check_quiet("t6.go_frame");
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("t6.respawn.grace", 32'(grace),     32'd1);
        check("t6.respawn.mask",  32'(ship_mask), 32'd1);
        check_quiet("t6.respawn");
        for (int k = 1; k <= 90; k++) begin
            overlap(); overlap();
            fpulse();
            check($sformatf("t6.spawn.ship_hit.f%0d", k), 32'(ship_hit), 32'd0);
            check($sformatf("t6.spawn.grace.f%0d", k), 32'(grace), (k < 90) ? 32'd1 : 32'd0);
        end

        // ---- game_over rising on the boundary cycle ----
        $display("section: game over on boundary");
        overlap(); overlap();
        step(1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        check_quiet("t6.go_fp");
        check("t6.go_fp.grace", 32'(grace), 32'd0);
        step(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        check("t6.go_fp.release", 32'(grace), 32'd1);

        // ---- reset coinciding with frame pulse discards the frame ----
        $display("section: reset on boundary");
        do_reset();
        overlap(); overlap();
        step(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
        resetN = 1'b0;
        fpulse();
        check_quiet("rst_fp");
        resetN = 1'b1;
        fpulse();
        check_quiet("rst_fp.next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
